// File: rtl/uart_pkg.sv
// Shared baud-rate definitions and phase-increment calculation for the UART paths.
// Latency: none (constants and an elaboration-time function only).
// Backpressure: not applicable.
package uart_pkg;

  localparam int unsigned DEF_OSR   = 16;
  localparam int unsigned DEF_ACC_W = 24;

  // baud_sel encoding into the standard rate table
  typedef enum logic [2:0] {
    BAUD_2400   = 3'd0,
    BAUD_4800   = 3'd1,
    BAUD_9600   = 3'd2,
    BAUD_19200  = 3'd3,
    BAUD_38400  = 3'd4,
    BAUD_57600  = 3'd5,
    BAUD_115200 = 3'd6,
    BAUD_230400 = 3'd7
  } baud_sel_e;

  localparam int unsigned BAUD_RATE [8] = '{
    2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400
  };

  // round(osr * baud * 2^acc_w / clk_hz); the caller keeps the low ACC_W bits.
  // Evaluated in 64 bits so the numerator cannot overflow for any table rate.
  function automatic logic [63:0] calc_inc(input longint unsigned clk_hz,
                                           input longint unsigned baud,
                                           input longint unsigned osr,
                                           input longint unsigned acc_w);
    logic [63:0] num;
    num = (osr * baud) << acc_w;
    return (num + (clk_hz / 64'd2)) / clk_hz;
  endfunction

endpackage

// File: rtl/uart_baud_gen_frac_if.sv
// Rate control and tick outputs of one fractional baud generator.
// Latency: none (wiring only).
// Backpressure: none; ticks are fire-and-forget pulses.
interface uart_baud_gen_frac_if
  import uart_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W
);
  logic             en;
  logic [2:0]       baud_sel;
  logic             use_cfg;
  logic [ACC_W-1:0] inc_cfg;
  logic             resync;
  logic             os_tick;
  logic             bit_tick;
  logic             mid_tick;
  logic             baud_clk;

  // Controller side: drives rate/phase controls, consumes ticks
  modport master (
    output en, baud_sel, use_cfg, inc_cfg, resync,
    input  os_tick, bit_tick, mid_tick, baud_clk
  );

  // Generator side
  modport slave (
    input  en, baud_sel, use_cfg, inc_cfg, resync,
    output os_tick, bit_tick, mid_tick, baud_clk
  );
endinterface

// File: rtl/uart_baud_lut.sv
// Standard-rate table: baud_sel -> phase increment, built at elaboration.
// Latency: combinational.
// Backpressure: not applicable.
module uart_baud_lut
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned OSR    = DEF_OSR,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic [2:0]       baud_sel_i,
  output logic [ACC_W-1:0] inc_o
);

  localparam logic [ACC_W-1:0] LUT [8] = '{
    ACC_W'(calc_inc(64'(CLK_HZ), 64'(BAUD_RATE[0]), 64'(OSR), 64'(ACC_W))),
    ACC_W'(calc_inc(64'(CLK_HZ), 64'(BAUD_RATE[1]), 64'(OSR), 64'(ACC_W))),
    ACC_W'(calc_inc(64'(CLK_HZ), 64'(BAUD_RATE[2]), 64'(OSR), 64'(ACC_W))),
    ACC_W'(calc_inc(64'(CLK_HZ), 64'(BAUD_RATE[3]), 64'(OSR), 64'(ACC_W))),
    ACC_W'(calc_inc(64'(CLK_HZ), 64'(BAUD_RATE[4]), 64'(OSR), 64'(ACC_W))),
    ACC_W'(calc_inc(64'(CLK_HZ), 64'(BAUD_RATE[5]), 64'(OSR), 64'(ACC_W))),
    ACC_W'(calc_inc(64'(CLK_HZ), 64'(BAUD_RATE[6]), 64'(OSR), 64'(ACC_W))),
    ACC_W'(calc_inc(64'(CLK_HZ), 64'(BAUD_RATE[7]), 64'(OSR), 64'(ACC_W)))
  };

  // Table lookup
  always_comb begin
    inc_o = LUT[baud_sel_i];
  end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional-N baud generator: OSRx oversample, bit, mid-bit ticks and baud_clk.
// Latency: ticks are registered, one cycle after the carrying accumulator update.
// Backpressure: none; en freezes all phase state and gates the ticks low.
module uart_baud_gen_frac
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned OSR    = DEF_OSR,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned CNT_W  = $clog2(OSR)
) (
  input logic                clk,
  input logic                rst,
  uart_baud_gen_frac_if.slave bif
);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(OSR - 1);
  localparam logic [CNT_W-1:0] CNT_MID_PRE = CNT_W'(OSR / 2 - 1);

  logic [ACC_W-1:0] lut_inc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;
  logic [3:0]       sel_cur;
  logic             rate_chg;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] os_cnt_q, os_cnt_d;
  logic [3:0]       sel_q, sel_d;
  logic [ACC_W-1:0] cfg_q, cfg_d;
  logic             os_tick_q, os_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             mid_tick_q, mid_tick_d;
  logic             baud_clk_q, baud_clk_d;

  uart_baud_lut #(
    .CLK_HZ (CLK_HZ),
    .OSR    (OSR),
    .ACC_W  (ACC_W)
  ) u_lut (
    .baud_sel_i (bif.baud_sel),
    .inc_o      (lut_inc)
  );

  assign inc     = bif.use_cfg ? bif.inc_cfg : lut_inc;
  assign sel_cur = {bif.use_cfg, bif.baud_sel};
  // A new runtime increment only counts as a rate change while it is selected
  assign rate_chg = (sel_cur != sel_q) || (bif.use_cfg && (bif.inc_cfg != cfg_q));
  assign sum      = {1'b0, acc_q} + {1'b0, inc};

  // Next phase, oversample count and tick generation
  always_comb begin
    acc_d      = acc_q;
    os_cnt_d   = os_cnt_q;
    sel_d      = sel_q;
    cfg_d      = cfg_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;
    baud_clk_d = baud_clk_q;
    if (bif.en) begin
      sel_d = sel_cur;
      if (bif.use_cfg) begin
        cfg_d = bif.inc_cfg;
      end
      if (bif.resync) begin
        // Restart the bit at its leading edge
        acc_d      = '0;
        os_cnt_d   = '0;
        baud_clk_d = 1'b1;
      end else if (rate_chg) begin
        // Restart phase at the new rate; baud_clk keeps its level
        acc_d    = '0;
        os_cnt_d = '0;
      end else begin
        acc_d = sum[ACC_W-1:0];
        if (sum[ACC_W]) begin
          os_tick_d = 1'b1;
          if (os_cnt_q == CNT_LAST) begin
            os_cnt_d   = '0;
            bit_tick_d = 1'b1;
            baud_clk_d = 1'b1;
          end else begin
            os_cnt_d = os_cnt_q + CNT_W'(1);
            if (os_cnt_q == CNT_MID_PRE) begin
              mid_tick_d = 1'b1;
              baud_clk_d = 1'b0;
            end
          end
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      os_cnt_q   <= '0;
      sel_q      <= '0;
      cfg_q      <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
      baud_clk_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      os_cnt_q   <= os_cnt_d;
      sel_q      <= sel_d;
      cfg_q      <= cfg_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      mid_tick_q <= mid_tick_d;
      baud_clk_q <= baud_clk_d;
    end
  end

  assign bif.os_tick  = os_tick_q;
  assign bif.bit_tick = bit_tick_q;
  assign bif.mid_tick = mid_tick_q;
  assign bif.baud_clk = baud_clk_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Self-checking bench for uart_baud_gen_frac: tick rates, phase alignment, gating, reset.
// Latency: expectations are queued at stimulus time and popped when the DUT responds.
// Backpressure: not applicable.
module tb_uart_baud_gen_frac;

  localparam longint CLK_HZ  = 50_000_000;
  localparam longint OSR     = 16;
  localparam int     ACC_W   = 24;
  localparam longint TWO_ACC = 64'd1 << ACC_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_baud_gen_frac_if #(.ACC_W(ACC_W)) bif ();

  uart_baud_gen_frac #(
    .CLK_HZ (50_000_000),
    .OSR    (16),
    .ACC_W  (ACC_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif.slave)
  );

  typedef struct {
    string  tag;
    longint val;
    longint tol;
  } exp_t;

  exp_t   sb_q[$];
  int     n_chk  = 0;
  int     n_pass = 0;

  longint os_total     = 0;
  longint n_bit        = 0;
  longint n_mid        = 0;
  longint os_ctr       = 0;
  longint os_since_bit = 0;
  longint last_bit_gap = 0;
  longint last_mid_gap = 0;
  longint os_at_mid    = 0;
  longint os_at_bit    = 0;

  longint inc0, inc2, inc3, inc6;
  longint c, b0, m0;

  // Reference increment: round(OSR * baud * 2^ACC_W / CLK_HZ)
  function automatic longint model_inc(longint baud);
    return (OSR * baud * TWO_ACC + CLK_HZ / 2) / CLK_HZ;
  endfunction

  // Accumulator updates from zero until the first carry
  function automatic longint first_carry(longint inc);
    return (TWO_ACC + inc - 1) / inc;
  endfunction

  // Nominal cycle span of n oversample periods
  function automatic longint span(longint inc, longint n);
    return (TWO_ACC * n) / inc;
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp, input longint tol);
    n_chk++;
    if (got >= exp - tol && got <= exp + tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
  endtask

  task automatic expect_val(input string tag, input longint val, input longint tol);
    exp_t e;
    e.tag = tag;
    e.val = val;
    e.tol = tol;
    sb_q.push_back(e);
  endtask

  task automatic sb_chk(input longint got);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_chk++;
      $display("FAIL sb_underflow: got %0d, expected no pending value", got);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, got, e.val, e.tol);
    end
  endtask

  // One clock; outputs observed on the falling edge
  task automatic step();
    @(negedge clk);
    if (bif.os_tick) begin
      os_total++;
      os_ctr++;
      os_since_bit++;
      if (bif.bit_tick) begin
        last_bit_gap = os_since_bit;
        os_since_bit = 0;
        os_at_bit    = os_ctr;
      end
      if (bif.mid_tick) begin
        last_mid_gap = os_since_bit;
        os_at_mid    = os_ctr;
      end
    end
    if (bif.bit_tick) n_bit++;
    if (bif.mid_tick) n_mid++;
  endtask

  function automatic longint evt_cnt(int which);
    return (which == 0) ? os_total : (which == 1) ? n_bit : n_mid;
  endfunction

  // which: 0 = os_tick, 1 = bit_tick, 2 = mid_tick
  task automatic wait_evt(input int which, input longint n, input longint budget,
                          output longint cyc);
    longint target;
    target = evt_cnt(which) + n;
    cyc    = 0;
    while (evt_cnt(which) < target && cyc < budget) begin
      step();
      cyc++;
    end
    if (evt_cnt(which) < target) chk("wait_timeout", evt_cnt(which), target, 0);
  endtask

  task automatic run_while(input logic lvl, input longint budget, output longint cyc);
    cyc = 0;
    while (bif.baud_clk === lvl && cyc < budget) begin
      step();
      cyc++;
    end
    if (cyc >= budget) chk("baud_level_timeout", cyc, budget - 1, 0);
  endtask

  initial begin
    inc0 = model_inc(2400);
    inc2 = model_inc(9600);
    inc3 = model_inc(19200);
    inc6 = model_inc(115200);

    // Reset held while enabled: outputs must stay low
    rst          = 1'b1;
    bif.en       = 1'b1;
    bif.baud_sel = 3'd2;
    bif.use_cfg  = 1'b0;
    bif.inc_cfg  = '0;
    bif.resync   = 1'b0;
    expect_val("rst_os_tick", 0, 0);
    expect_val("rst_bit_tick", 0, 0);
    expect_val("rst_mid_tick", 0, 0);
    expect_val("rst_baud_clk", 0, 0);
    repeat (3) step();
    sb_chk(bif.os_tick);
    sb_chk(bif.bit_tick);
    sb_chk(bif.mid_tick);
    sb_chk(bif.baud_clk);

    // 9600 baud from reset
    rst = 1'b0;
    expect_val("first_os_9600", 1 + first_carry(inc2), 1);
    wait_evt(0, 1, 2000, c);
    sb_chk(c);
    b0 = n_bit;
    m0 = n_mid;
    expect_val("span100_9600", span(inc2, 100), 1);
    expect_val("bits_in_100", 6, 0);
    expect_val("mids_in_100", 6, 0);
    expect_val("bit_gap_os", 16, 0);
    expect_val("mid_after_bit_os", 8, 0);
    wait_evt(0, 100, 40000, c);
    sb_chk(c);
    sb_chk(n_bit - b0);
    sb_chk(n_mid - m0);
    sb_chk(last_bit_gap);
    sb_chk(last_mid_gap);

    // 115200 baud, rate change restarts phase
    bif.baud_sel = 3'd6;
    expect_val("first_os_115200", 1 + first_carry(inc6), 1);
    wait_evt(0, 1, 200, c);
    sb_chk(c);
    expect_val("span500_115200", span(inc6, 500), 1);
    wait_evt(0, 500, 20000, c);
    sb_chk(c);
    run_while(1'b1, 1000, c);
    run_while(1'b0, 1000, c);
    expect_val("baud_clk_high", span(inc6, 8), 1);
    expect_val("baud_clk_low", span(inc6, 8), 1);
    run_while(1'b1, 1000, c);
    sb_chk(c);
    run_while(1'b0, 1000, c);
    sb_chk(c);

    // Runtime increment of half the accumulator range
    bif.use_cfg = 1'b1;
    bif.inc_cfg = 24'h80_0000;
    expect_val("first_os_cfg", 3, 0);
    wait_evt(0, 1, 100, c);
    sb_chk(c);
    expect_val("span10_cfg", 20, 0);
    wait_evt(0, 10, 100, c);
    sb_chk(c);
    wait_evt(1, 1, 100, c);
    expect_val("bit_period_cfg", 32, 0);
    wait_evt(1, 1, 100, c);
    sb_chk(c);

    // Zero increment: silence
    bif.inc_cfg = '0;
    b0 = os_total;
    m0 = n_bit;
    expect_val("inc0_os_ticks", 0, 0);
    expect_val("inc0_bit_ticks", 0, 0);
    repeat (1000) step();
    sb_chk(os_total - b0);
    sb_chk(n_bit - m0);

    // Resync after mid-bit (baud_clk low) at 115200
    bif.use_cfg  = 1'b0;
    bif.baud_sel = 3'd6;
    wait_evt(1, 1, 2000, c);
    wait_evt(0, 10, 1000, c);
    bif.resync = 1'b1;
    os_ctr     = 0;
    expect_val("resync_no_tick", 0, 0);
    expect_val("resync_baud_clk", 1, 0);
    step();
    bif.resync = 1'b0;
    sb_chk(bif.os_tick);
    sb_chk(bif.baud_clk);
    expect_val("resync_mid_os", 8, 0);
    wait_evt(2, 1, 1000, c);
    sb_chk(os_at_mid);
    expect_val("resync_bit_os", 16, 0);
    wait_evt(1, 1, 1000, c);
    sb_chk(os_at_bit);

    // Rate change 9600 -> 19200 mid-bit
    bif.baud_sel = 3'd2;
    wait_evt(1, 1, 6000, c);
    wait_evt(0, 5, 2000, c);
    bif.baud_sel = 3'd3;
    os_ctr       = 0;
    expect_val("first_os_19200", 1 + first_carry(inc3), 1);
    wait_evt(0, 1, 1000, c);
    sb_chk(c);
    expect_val("chg_mid_os", 8, 0);
    wait_evt(2, 1, 2000, c);
    sb_chk(os_at_mid);
    expect_val("span10_19200", span(inc3, 10), 1);
    wait_evt(0, 10, 3000, c);
    sb_chk(c);

    // Disabled for 500 cycles at os_cnt = 3; resync and rate change must be ignored
    wait_evt(1, 1, 3000, c);
    wait_evt(0, 3, 1000, c);
    bif.en       = 1'b0;
    bif.baud_sel = 3'd5;
    b0 = os_total;
    m0 = n_bit + n_mid;
    expect_val("en0_os_ticks", 0, 0);
    expect_val("en0_bit_mid_ticks", 0, 0);
    expect_val("en0_baud_clk", 1, 0);
    for (int i = 0; i < 500; i++) begin
      bif.resync = (i == 100);
      step();
    end
    bif.resync = 1'b0;
    sb_chk(os_total - b0);
    sb_chk(n_bit + n_mid - m0);
    sb_chk(bif.baud_clk);
    bif.baud_sel = 3'd3;
    bif.en       = 1'b1;
    os_ctr       = 0;
    expect_val("reenable_mid_os", 5, 0);
    wait_evt(2, 1, 2000, c);
    sb_chk(os_at_mid);

    // Reset mid-bit while baud_clk is high, then restart at 2400 without a rate change
    wait_evt(1, 1, 3000, c);
    wait_evt(0, 2, 1000, c);
    rst          = 1'b1;
    bif.baud_sel = 3'd0;
    expect_val("midrst_os_tick", 0, 0);
    expect_val("midrst_bit_tick", 0, 0);
    expect_val("midrst_mid_tick", 0, 0);
    expect_val("midrst_baud_clk", 0, 0);
    step();
    sb_chk(bif.os_tick);
    sb_chk(bif.bit_tick);
    sb_chk(bif.mid_tick);
    sb_chk(bif.baud_clk);
    rst = 1'b0;
    expect_val("first_os_2400_after_rst", first_carry(inc0), 1);
    wait_evt(0, 1, 3000, c);
    sb_chk(c);

    if (sb_q.size() != 0) chk("sb_leftover", sb_q.size(), 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
